ps2_hex_entry: RTL and testbench

//   Keyboard hex-entry front end for the MMA board UI: receives PS/2 frames (device-to-host) from the

---
 rtl/ps2_hex_entry.sv | 192 +++++++++++++++++++
 tb/tb_ps2_hex_entry.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_hex_entry.sv
// PS/2 device-to-host receiver with scan-code set 2 hex-key decoder.
// Assembles typed hex digits into a 32-bit shift-in value.
module ps2_hex_entry #(
   parameter int unsigned FILTER_CYCLES  = 8,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   input  logic        clear,
   output logic [31:0] value,
   output logic [3:0]  digit,
   output logic        digit_valid,
   output logic        frame_error
);

   localparam int unsigned FCW = $clog2(FILTER_CYCLES + 1);
   localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} rx_state_t;

   rx_state_t      state, state_nxt;
   logic           clk_s1, clk_s2, dat_s1, dat_s2;
   logic           clk_filt, clk_filt_d;
   logic [FCW-1:0] filt_cnt;
   logic           strobe;
   logic [TCW-1:0] to_cnt;
   logic           timeout;
   logic [2:0]     bitcnt;
   logic [7:0]     shift_byte;
   logic           parity_ok;
   logic           byte_ready, rdy_nxt, err_nxt;
   logic           brk, ext, brk_nxt, ext_nxt;
   logic [31:0]    value_nxt;
   logic [3:0]     digit_nxt;
   logic           dv_nxt;
   logic [4:0]     hex;

   // Filtered clock only follows the synchronised input after a full run of equal samples
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clk_s1     <= 1'b1;
         clk_s2     <= 1'b1;
         dat_s1     <= 1'b1;
         dat_s2     <= 1'b1;
         clk_filt   <= 1'b1;
         clk_filt_d <= 1'b1;
         filt_cnt   <= '0;
      end else begin
         clk_s1     <= ps2_clk;
         clk_s2     <= clk_s1;
         dat_s1     <= ps2_data;
         dat_s2     <= dat_s1;
         clk_filt_d <= clk_filt;
         if (clk_s2 == clk_filt) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FCW'(FILTER_CYCLES - 1)) begin
            clk_filt <= clk_s2;
            filt_cnt <= '0;
         end else begin
            filt_cnt <= filt_cnt + 1'b1;
         end
      end
   end

   assign strobe  = clk_filt_d & ~clk_filt;
   assign timeout = (state != S_IDLE) && !strobe && (to_cnt == TCW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (timeout) begin
         state_nxt = S_IDLE;
      end else if (strobe) begin
         case (state)
            S_IDLE:   if (!dat_s2) state_nxt = S_DATA;
            S_DATA:   if (bitcnt == 3'd7) state_nxt = S_PARITY;
            S_PARITY: state_nxt = S_STOP;
            default:  state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      rdy_nxt = 1'b0;
      err_nxt = timeout;
      if (strobe && state == S_STOP) begin
         if (dat_s2 && parity_ok) rdy_nxt = 1'b1;
         else                     err_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bitcnt      <= '0;
         shift_byte  <= '0;
         parity_ok   <= 1'b0;
         to_cnt      <= '0;
         byte_ready  <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         byte_ready  <= rdy_nxt;
         frame_error <= err_nxt;
         if (state == S_IDLE || strobe) to_cnt <= '0;
         else                           to_cnt <= to_cnt + 1'b1;
         if (strobe) begin
            case (state)
               S_IDLE: bitcnt <= '0;
               S_DATA: begin
                  shift_byte <= {dat_s2, shift_byte[7:1]};
                  bitcnt     <= bitcnt + 3'd1;
               end
               S_PARITY: parity_ok <= ^{shift_byte, dat_s2};
               default: ;
            endcase
         end
      end
   end

   function automatic logic [4:0] hex_lookup(input logic [7:0] code);
      case (code)
         8'h45: hex_lookup = 5'h10;
         8'h16: hex_lookup = 5'h11;
         8'h1E: hex_lookup = 5'h12;
         8'h26: hex_lookup = 5'h13;
         8'h25: hex_lookup = 5'h14;
         8'h2E: hex_lookup = 5'h15;
         8'h36: hex_lookup = 5'h16;
         8'h3D: hex_lookup = 5'h17;
         8'h3E: hex_lookup = 5'h18;
         8'h46: hex_lookup = 5'h19;
         8'h1C: hex_lookup = 5'h1A;
         8'h32: hex_lookup = 5'h1B;
         8'h21: hex_lookup = 5'h1C;
         8'h23: hex_lookup = 5'h1D;
         8'h24: hex_lookup = 5'h1E;
         8'h2B: hex_lookup = 5'h1F;
         default: hex_lookup = 5'h00;
      endcase
   endfunction

   // shift_byte is stable while byte_ready is high; a new frame needs several strobes first
   always_comb begin
      value_nxt = value;
      digit_nxt = digit;
      dv_nxt    = 1'b0;
      brk_nxt   = brk;
      ext_nxt   = ext;
      hex       = hex_lookup(shift_byte);
      if (byte_ready) begin
         if (shift_byte == 8'hF0) begin
            brk_nxt = 1'b1;
         end else if (shift_byte == 8'hE0) begin
            ext_nxt = 1'b1;
         end else if (brk || ext) begin
            brk_nxt = 1'b0;
            ext_nxt = 1'b0;
         end else if (hex[4]) begin
            value_nxt = {value[27:0], hex[3:0]};
            digit_nxt = hex[3:0];
            dv_nxt    = 1'b1;
         end else if (shift_byte == 8'h66) begin
            value_nxt = {4'h0, value[31:4]};
         end else if (shift_byte == 8'h76) begin
            value_nxt = '0;
         end
      end
      if (clear) value_nxt = '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         value       <= '0;
         digit       <= '0;
         digit_valid <= 1'b0;
         brk         <= 1'b0;
         ext         <= 1'b0;
      end else begin
         value       <= value_nxt;
         digit       <= digit_nxt;
         digit_valid <= dv_nxt;
         brk         <= brk_nxt;
         ext         <= ext_nxt;
      end
   end

endmodule

// File: tb/tb_ps2_hex_entry.sv
// Directed bench for ps2_hex_entry: PS/2 frames driven bit by bit, expected values hand-computed.
// PS/2 timing is scaled to 600 ns per bit (data changes mid-low) with a 10 us timeout.
module tb_ps2_hex_entry;

   localparam int unsigned HALF = 30;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic        clear = 1'b0;
   logic [31:0] value;
   logic [3:0]  digit;
   logic        digit_valid;
   logic        frame_error;

   int n_checks = 0;
   int n_pass   = 0;
   int dv_cnt   = 0;
   int fe_cnt   = 0;
   int overlap  = 0;
   int wide     = 0;
   logic dv_q = 1'b0;
   logic fe_q = 1'b0;
   int dv0, fe0;

   ps2_hex_entry #(.FILTER_CYCLES(8), .TIMEOUT_CYCLES(1000)) dut (
      .clk         (clk),
      .reset       (reset),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .clear       (clear),
      .value       (value),
      .digit       (digit),
      .digit_valid (digit_valid),
      .frame_error (frame_error)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (digit_valid) dv_cnt <= dv_cnt + 1;
      if (frame_error) fe_cnt <= fe_cnt + 1;
      if (digit_valid && frame_error) overlap <= overlap + 1;
      if ((digit_valid && dv_q) || (frame_error && fe_q)) wide <= wide + 1;
      dv_q <= digit_valid;
      fe_q <= frame_error;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic cyc(input int unsigned n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic send_bits(input logic [10:0] fr, input int unsigned nbits);
      ps2_data = fr[0];
      cyc(HALF);
      for (int unsigned i = 0; i < nbits; i++) begin
         ps2_clk = 1'b0;
         cyc(HALF / 2);
         ps2_data = (i + 1 < nbits) ? fr[i + 1] : 1'b1;
         cyc(HALF / 2);
         ps2_clk = 1'b1;
         cyc(HALF);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic bad_par, input logic bad_stop);
      logic p;
      p = (~^b) ^ bad_par;
      send_bits({~bad_stop, p, b, 1'b0}, 11);
      cyc(10);
   endtask

   initial begin
      cyc(3);
      check("rst_value", value, 32'h0);
      check("rst_digit", {28'h0, digit}, 32'h0);
      check("rst_dv", {31'h0, digit_valid}, 32'h0);
      check("rst_fe", {31'h0, frame_error}, 32'h0);
      reset = 1'b1;
      cyc(10);

      // 1: digits 1,2,3,4
      dv0 = dv_cnt;
      send_byte(8'h16, 0, 0);
      send_byte(8'h1E, 0, 0);
      send_byte(8'h26, 0, 0);
      send_byte(8'h25, 0, 0);
      check("t1_value", value, 32'h0000_1234);
      check("t1_digit", {28'h0, digit}, 32'h4);
      check("t1_dv_count", dv_cnt - dv0, 4);

      // 2: fill to 1234_5678, append A, then a break sequence
      send_byte(8'h2E, 0, 0);
      send_byte(8'h36, 0, 0);
      send_byte(8'h3D, 0, 0);
      send_byte(8'h3E, 0, 0);
      check("t2_fill", value, 32'h1234_5678);
      dv0 = dv_cnt;
      send_byte(8'h1C, 0, 0);
      check("t2_append_a", value, 32'h2345_678A);
      check("t2_digit_a", {28'h0, digit}, 32'hA);
      send_byte(8'hF0, 0, 0);
      send_byte(8'h1C, 0, 0);
      check("t2_break", value, 32'h2345_678A);
      check("t2_dv_once", dv_cnt - dv0, 1);

      // 3: bad parity, bad stop
      fe0 = fe_cnt;
      send_byte(8'h16, 1, 0);
      check("t3_par_fe", fe_cnt - fe0, 1);
      check("t3_par_value", value, 32'h2345_678A);
      send_byte(8'h16, 0, 1);
      check("t3_stop_fe", fe_cnt - fe0, 2);
      check("t3_stop_value", value, 32'h2345_678A);

      // 4: abort after 4 data bits, timeout, then a good frame
      fe0 = fe_cnt;
      send_bits({1'b1, 1'b0, 8'h45, 1'b0}, 5);
      cyc(500);
      check("t4_no_early_fe", fe_cnt - fe0, 0);
      cyc(700);
      check("t4_timeout_fe", fe_cnt - fe0, 1);
      send_byte(8'h45, 0, 0);
      check("t4_value", value, 32'h3456_78A0);
      check("t4_digit", {28'h0, digit}, 32'h0);

      // 5: clear, ABCD, extended key, backspace, escape
      clear = 1'b1;
      cyc(1);
      clear = 1'b0;
      cyc(1);
      check("t5_clear", value, 32'h0);
      send_byte(8'h1C, 0, 0);
      send_byte(8'h32, 0, 0);
      send_byte(8'h21, 0, 0);
      send_byte(8'h23, 0, 0);
      check("t5_abcd", value, 32'h0000_ABCD);
      dv0 = dv_cnt;
      send_byte(8'hE0, 0, 0);
      send_byte(8'h75, 0, 0);
      check("t5_ext_value", value, 32'h0000_ABCD);
      check("t5_ext_dv", dv_cnt - dv0, 0);
      send_byte(8'h66, 0, 0);
      check("t5_bksp", value, 32'h0000_0ABC);
      send_byte(8'h76, 0, 0);
      check("t5_esc", value, 32'h0);

      // 6: async reset mid-frame, then a short glitch on ps2_clk
      send_byte(8'h16, 0, 0);
      check("t6_pre", value, 32'h1);
      send_bits({1'b1, 1'b0, 8'h26, 1'b0}, 3);
      #4;
      reset = 1'b0;
      #1;
      check("t6_rst_value", value, 32'h0);
      check("t6_rst_digit", {28'h0, digit}, 32'h0);
      check("t6_rst_dv", {31'h0, digit_valid}, 32'h0);
      check("t6_rst_fe", {31'h0, frame_error}, 32'h0);
      ps2_clk = 1'b1;
      ps2_data = 1'b1;
      cyc(5);
      reset = 1'b1;
      cyc(5);
      fe0 = fe_cnt;
      ps2_data = 1'b0;
      ps2_clk = 1'b0;
      #5;
      ps2_clk = 1'b1;
      cyc(20);
      ps2_data = 1'b1;
      cyc(20);
      send_byte(8'h26, 0, 0);
      check("t6_glitch_value", value, 32'h3);
      check("t6_glitch_fe", fe_cnt - fe0, 0);

      check("overlap", overlap, 0);
      check("pulse_width", wide, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
